// File: rtl/snake_step_scheduler.sv
// rtl/snake_step_scheduler.sv - per-tick move sequencer with serial collision scan for the two-snake core
module snake_step_scheduler #(
    parameter int MAX_LEN         = 15,
    parameter int MAX_LEN_BIT_LEN = 4,
    parameter int CLK_DIV_NUM     = 1250
) (
    input  logic                       clk_raw,
    input  logic                       rst_n,
    input  logic [12:0]                keystroke,
    input  logic [9:0]                 head1,
    input  logic [9:0]                 head2,
    input  logic [MAX_LEN_BIT_LEN-1:0] len1,
    input  logic [MAX_LEN_BIT_LEN-1:0] len2,
    input  logic [9:0]                 food1,
    input  logic [9:0]                 food2,
    output logic                       seg_rd_sel,
    output logic [MAX_LEN_BIT_LEN-1:0] seg_rd_idx,
    input  logic [9:0]                 seg_rd_data,
    output logic [9:0]                 next_head1,
    output logic [9:0]                 next_head2,
    output logic                       step1,
    output logic                       step2,
    output logic                       grow1,
    output logic                       grow2,
    output logic                       dead1,
    output logic                       dead2,
    output logic                       restart,
    output logic                       busy
);

    localparam int IW        = MAX_LEN_BIT_LEN;
    localparam int CNT_W     = $clog2(CLK_DIV_NUM);
    localparam int SCAN_W    = $clog2(2 * MAX_LEN + 1);
    localparam logic [IW:0] MAX_LEN_W = (IW + 1)'(MAX_LEN);

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    generate
        if (CLK_DIV_NUM <= 2 * MAX_LEN + 5) begin : g_div_check
            $error("CLK_DIV_NUM too small to fit one full move sequence per tick");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SCAN,
        S_RESOLVE,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]        dir1_q, dir1_d, dir2_q, dir2_d;
    logic [9:0]        nh1_q, nh1_d, nh2_q, nh2_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_sel_q, rd_sel_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic              hit1_q, hit1_d, hit2_q, hit2_d;
    logic              dead1_q, dead1_d, dead2_q, dead2_d;
    logic              ks8_q, ks8_d;
    logic              restart_q, restart_d;

    logic          restart_req, pause, two_player, tick;
    logic          scan_issue, scan_sel, seg_ok, head_on;
    logic [IW-1:0] scan_idx;
    logic [3:0]    new_dir1, new_dir2;
    logic          unused_keys;

    // A request is honoured only when exactly one bit is set and it does not reverse the snake.
    function automatic logic [3:0] pick_dir(input logic [3:0] req, input logic [3:0] cur);
        logic       one_hot;
        logic [3:0] reverse;
        one_hot = (req != 4'b0000) && ((req & (req - 4'd1)) == 4'b0000);
        reverse = {cur[2], cur[3], cur[0], cur[1]};
        return (one_hot && (req != reverse)) ? req : cur;
    endfunction

    function automatic logic [9:0] move_head(input logic [9:0] h, input logic [3:0] d);
        logic [4:0] x;
        logic [4:0] y;
        x = h[9:5];
        y = h[4:0];
        if (d[3])      x = x + 5'd1;
        else if (d[2]) x = x - 5'd1;
        else if (d[1]) y = y + 5'd1;
        else if (d[0]) y = y - 5'd1;
        return {x, y};
    endfunction

    assign restart_req = keystroke[8];
    assign pause       = keystroke[9];
    assign two_player  = keystroke[12];
    assign unused_keys = ^keystroke[11:10];

    assign tick     = !pause && (cnt_q == CNT_W'(CLK_DIV_NUM - 1));
    assign new_dir1 = pick_dir(keystroke[3:0], dir1_q);
    assign new_dir2 = pick_dir(keystroke[7:4], dir2_q);

    // Scan slots 0..MAX_LEN-1 read snake1, the next MAX_LEN read snake2, the last slot only drains.
    assign scan_issue = (state_q == S_SCAN) && (scan_cnt_q < SCAN_W'(2 * MAX_LEN));
    assign scan_sel   = scan_cnt_q >= SCAN_W'(MAX_LEN);
    assign scan_idx   = scan_sel ? IW'(scan_cnt_q - SCAN_W'(MAX_LEN)) : IW'(scan_cnt_q);

    assign seg_ok  = rd_vld_q && (rd_idx_q < (rd_sel_q ? len2 : len1)) && (seg_rd_data != 10'h3FF);
    assign head_on = two_player && (nh1_q == nh2_q);

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (tick) state_d = S_LATCH;
            S_LATCH:   state_d = S_SCAN;
            S_SCAN:    if (scan_cnt_q == SCAN_W'(2 * MAX_LEN)) state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (restart_req) state_d = S_IDLE;
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        seg_rd_sel = scan_issue && scan_sel;
        seg_rd_idx = scan_issue ? scan_idx : '0;
        next_head1 = nh1_q;
        next_head2 = nh2_q;
        step1      = (state_q == S_COMMIT) && !dead1_q;
        step2      = (state_q == S_COMMIT) && two_player && !dead2_q;
        grow1      = step1 && ((nh1_q == food1) || (nh1_q == food2)) && ({1'b0, len1} < MAX_LEN_W);
        grow2      = step2 && ((nh2_q == food1) || (nh2_q == food2)) && ({1'b0, len2} < MAX_LEN_W);
        dead1      = dead1_q;
        dead2      = dead2_q;
        restart    = restart_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        scan_cnt_d = '0;
        dir1_d     = dir1_q;
        dir2_d     = dir2_q;
        nh1_d      = nh1_q;
        nh2_d      = nh2_q;
        rd_vld_d   = 1'b0;
        rd_sel_d   = scan_sel;
        rd_idx_d   = scan_idx;
        hit1_d     = hit1_q;
        hit2_d     = hit2_q;
        dead1_d    = dead1_q;
        dead2_d    = dead2_q;
        ks8_d      = restart_req;
        restart_d  = restart_req && !ks8_q;

        if (!pause) cnt_d = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_LATCH: begin
                dir1_d = new_dir1;
                dir2_d = new_dir2;
                nh1_d  = move_head(head1, new_dir1);
                nh2_d  = move_head(head2, new_dir2);
                hit1_d = 1'b0;
                hit2_d = 1'b0;
            end
            S_SCAN: begin
                scan_cnt_d = scan_cnt_q + 1'b1;
                rd_vld_d   = scan_issue;
                if (seg_ok && (seg_rd_data == nh1_q)) hit1_d = 1'b1;
                if (seg_ok && (seg_rd_data == nh2_q)) hit2_d = 1'b1;
            end
            S_RESOLVE: begin
                dead1_d = dead1_q | hit1_q | head_on;
                dead2_d = dead2_q | (two_player & (hit2_q | head_on));
            end
            default: ;
        endcase

        if (restart_req) begin
            cnt_d      = '0;
            scan_cnt_d = '0;
            dir1_d     = DIR_RIGHT;
            dir2_d     = DIR_LEFT;
            rd_vld_d   = 1'b0;
            hit1_d     = 1'b0;
            hit2_d     = 1'b0;
            dead1_d    = 1'b0;
            dead2_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            scan_cnt_q <= '0;
            dir1_q     <= DIR_RIGHT;
            dir2_q     <= DIR_LEFT;
            nh1_q      <= '0;
            nh2_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_idx_q   <= '0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            dead1_q    <= 1'b0;
            dead2_q    <= 1'b0;
            ks8_q      <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            scan_cnt_q <= scan_cnt_d;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
            nh1_q      <= nh1_d;
            nh2_q      <= nh2_d;
            rd_vld_q   <= rd_vld_d;
            rd_sel_q   <= rd_sel_d;
            rd_idx_q   <= rd_idx_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            dead1_q    <= dead1_d;
            dead2_q    <= dead2_d;
            ks8_q      <= ks8_d;
            restart_q  <= restart_d;
        end
    end

    logic unused_dirs;
    assign unused_dirs = ^{DIR_UP, DIR_DOWN};

endmodule

// File: tb/tb_snake_step_scheduler.sv
// tb/tb_snake_step_scheduler.sv - scoreboard bench for snake_step_scheduler with a game-rule reference model
module tb_snake_step_scheduler;

    localparam int MAX_LEN = 15;
    localparam int IW      = 4;
    localparam int DIV     = 64;
    localparam int SEQ_LEN = 2 * MAX_LEN + 4;

    logic          clk_raw = 1'b0;
    logic          rst_n;
    logic [12:0]   keystroke;
    logic [9:0]    head1, head2, food1, food2;
    logic [IW-1:0] len1, len2;
    logic          seg_rd_sel;
    logic [IW-1:0] seg_rd_idx;
    logic [9:0]    seg_rd_data;
    logic [9:0]    next_head1, next_head2;
    logic          step1, step2, grow1, grow2, dead1, dead2, restart, busy;

    logic [9:0] body1 [16];
    logic [9:0] body2 [16];

    typedef struct {
        logic [9:0] nh1;
        logic [9:0] nh2;
        bit s1, s2, g1, g2, d1, d2, aborted;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_dir1  = 3;
    int   m_dir2  = 2;
    bit   m_dead1 = 0;
    bit   m_dead2 = 0;

    snake_step_scheduler #(.MAX_LEN(MAX_LEN), .MAX_LEN_BIT_LEN(IW), .CLK_DIV_NUM(DIV)) dut (
        .clk_raw(clk_raw), .rst_n(rst_n), .keystroke(keystroke),
        .head1(head1), .head2(head2), .len1(len1), .len2(len2),
        .food1(food1), .food2(food2),
        .seg_rd_sel(seg_rd_sel), .seg_rd_idx(seg_rd_idx), .seg_rd_data(seg_rd_data),
        .next_head1(next_head1), .next_head2(next_head2),
        .step1(step1), .step2(step2), .grow1(grow1), .grow2(grow2),
        .dead1(dead1), .dead2(dead2), .restart(restart), .busy(busy)
    );

    always #5 clk_raw = ~clk_raw;

    always @(posedge clk_raw) seg_rd_data <= seg_rd_sel ? body2[seg_rd_idx] : body1[seg_rd_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] pos(input int x, input int y);
        logic [4:0] xx, yy;
        xx = 5'(x);
        yy = 5'(y);
        return {xx, yy};
    endfunction

    function automatic logic [9:0] rnd_pos();
        return pos(8 + $urandom_range(0, 5), 8 + $urandom_range(0, 5));
    endfunction

    // Directions: 0 up, 1 down, 2 left, 3 right; opposite pairs differ in bit 0.
    function automatic int m_pick(input logic [3:0] f, input int cur);
        int nd;
        nd = cur;
        if ($countones(f) != 1) return cur;
        for (int i = 0; i < 4; i++) if (f[i]) nd = i;
        if (nd == (cur ^ 1)) return cur;
        return nd;
    endfunction

    function automatic logic [9:0] m_move(input logic [9:0] h, input int d);
        int x, y;
        x = int'(h[9:5]);
        y = int'(h[4:0]);
        case (d)
            0:       y = (y + 31) % 32;
            1:       y = (y + 1) % 32;
            2:       x = (x + 31) % 32;
            default: x = (x + 1) % 32;
        endcase
        return pos(x, y);
    endfunction

    function automatic bit m_hit(input logic [9:0] p);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len1) && body1[i] != 10'h3FF && body1[i] == p) return 1'b1;
            if (i < int'(len2) && body2[i] != 10'h3FF && body2[i] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_bodies();
        for (int i = 0; i < 16; i++) begin
            body1[i] = 10'h3FF;
            body2[i] = 10'h3FF;
        end
    endtask

    task automatic wait_busy(input logic v, input string name);
        int n;
        n = 0;
        while (busy !== v && n < 400) begin
            @(negedge clk_raw);
            n++;
        end
        if (busy !== v) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: busy stayed %0b, required %0b", name, busy, v);
        end
    endtask

    task automatic do_tick();
        exp_t e;
        bit   tp, k1, k2;
        tp     = keystroke[12];
        m_dir1 = m_pick(keystroke[3:0], m_dir1);
        m_dir2 = m_pick(keystroke[7:4], m_dir2);
        e.nh1  = m_move(head1, m_dir1);
        e.nh2  = m_move(head2, m_dir2);
        k1     = m_hit(e.nh1) || (tp && e.nh1 == e.nh2);
        k2     = tp && (m_hit(e.nh2) || e.nh1 == e.nh2);
        m_dead1 = m_dead1 | k1;
        m_dead2 = m_dead2 | k2;
        e.s1   = !m_dead1;
        e.s2   = tp && !m_dead2;
        e.g1   = e.s1 && (e.nh1 == food1 || e.nh1 == food2) && int'(len1) < MAX_LEN;
        e.g2   = e.s2 && (e.nh2 == food1 || e.nh2 == food2) && int'(len2) < MAX_LEN;
        e.d1   = m_dead1;
        e.d2   = m_dead2;
        e.aborted = 1'b0;
        exp_q.push_back(e);
        wait_busy(1'b1, "tick_start");
        wait_busy(1'b0, "tick_end");
    endtask

    task automatic push_aborted();
        exp_t e;
        e = '{nh1: 10'h0, nh2: 10'h0, s1: 0, s2: 0, g1: 0, g2: 0, d1: 0, d2: 0, aborted: 1};
        exp_q.push_back(e);
    endtask

    task automatic do_restart(input string name);
        keystroke[8] = 1'b1;
        @(negedge clk_raw);
        check({name, "_restart_hi"}, restart, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_dead1"}, dead1, 0);
        check({name, "_dead2"}, dead2, 0);
        keystroke[8] = 1'b0;
        @(negedge clk_raw);
        check({name, "_restart_lo"}, restart, 0);
        m_dir1 = 3;
        m_dir2 = 2;
        m_dead1 = 0;
        m_dead2 = 0;
    endtask

    initial begin : monitor
        exp_t e;
        int   blen, stray;
        logic c1, c2, cg1, cg2;
        blen = 0; stray = 0; c1 = 0; c2 = 0; cg1 = 0; cg2 = 0;
        forever begin
            @(negedge clk_raw);
            if (busy === 1'b1) begin
                blen++;
                if (blen == SEQ_LEN) begin
                    c1 = step1; c2 = step2; cg1 = grow1; cg2 = grow2;
                end else if (step1 | step2 | grow1 | grow2) begin
                    stray++;
                end
            end else begin
                if (step1 | step2 | grow1 | grow2) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL idle_pulse: step/grow %0b%0b%0b%0b while not busy, required 0000",
                             step1, step2, grow1, grow2);
                end
                if (blen > 0) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL seq_unexpected: sequence of %0d cycles, required none", blen);
                    end else begin
                        e = exp_q.pop_front();
                        check("stray_pulse", stray, 0);
                        check("step1", c1, e.s1);
                        check("step2", c2, e.s2);
                        check("grow1", cg1, e.g1);
                        check("grow2", cg2, e.g2);
                        if (!e.aborted) begin
                            check("seq_len", blen, SEQ_LEN);
                            check("next_head1", next_head1, e.nh1);
                            check("next_head2", next_head2, e.nh2);
                            check("dead1", dead1, e.d1);
                            check("dead2", dead2, e.d2);
                        end
                    end
                    blen = 0; stray = 0; c1 = 0; c2 = 0; cg1 = 0; cg2 = 0;
                end
            end
        end
    end

    initial begin : stim
        int busy_seen;
        rst_n = 1'b0;
        keystroke = '0;
        head1 = '0; head2 = '0; food1 = '0; food2 = '0; len1 = '0; len2 = '0;
        clear_bodies();
        repeat (2) @(negedge clk_raw);
        check("rst_busy", busy, 0);
        check("rst_steps", {step1, step2, grow1, grow2}, 0);
        check("rst_heads", {next_head1, next_head2}, 0);
        check("rst_rd", {seg_rd_sel, seg_rd_idx}, 0);
        check("rst_flags", {dead1, dead2, restart}, 0);
        rst_n = 1'b1;

        // Basic move, two-player with snake2 far away.
        head1 = pos(3, 3); len1 = 2; body1[0] = pos(3, 3); body1[1] = pos(2, 3);
        head2 = pos(20, 20); len2 = 1; body2[0] = pos(20, 20);
        food1 = pos(30, 30); food2 = pos(30, 30);
        keystroke = 13'b1_0000_0000_1000;
        do_tick();
        check("t1_head1", next_head1, pos(4, 3));

        // Food, then food at full length.
        keystroke = 13'b0_0000_0000_1000;
        len2 = 0; food1 = pos(4, 3);
        do_tick();
        len1 = 15;
        for (int i = 0; i < 15; i++) body1[i] = pos(3, 3 + i);
        do_tick();

        // Reversal, wrap, two-hot request.
        clear_bodies();
        head1 = pos(31, 0); len1 = 1; body1[0] = pos(31, 0);
        keystroke[3:0] = 4'b0100;
        do_tick();
        check("t5_wrap_x", next_head1, pos(0, 0));
        keystroke[3:0] = 4'b1001;
        do_tick();
        check("t5_two_hot", next_head1, pos(0, 0));
        head1 = pos(0, 0); body1[0] = pos(0, 0);
        keystroke[3:0] = 4'b0001;
        do_tick();
        check("t5_wrap_y", next_head1, pos(0, 31));

        // Self collision, then the dead snake stays dead with no pulses.
        clear_bodies();
        head1 = pos(9, 13); len1 = 5;
        body1[0] = pos(9, 13); body1[1] = pos(9, 14); body1[2] = pos(8, 14);
        body1[3] = pos(8, 13); body1[4] = pos(8, 12);
        keystroke[3:0] = 4'b0100;
        do_tick();
        check("t2_head1", next_head1, pos(8, 13));
        keystroke[3:0] = 4'b0000;
        repeat (3) do_tick();
        check("t2_still_dead", dead1, 1);

        // Pause holds off ticks; restart mid-scan aborts the sequence.
        keystroke[9] = 1'b1;
        busy_seen = 0;
        repeat (3 * DIV) begin
            @(negedge clk_raw);
            if (busy | step1 | step2) busy_seen++;
        end
        check("pause_busy_cycles", busy_seen, 0);
        push_aborted();
        keystroke[9] = 1'b0;
        wait_busy(1'b1, "pause_release");
        repeat (10) @(negedge clk_raw);
        do_restart("mid_scan");

        // Head-on collision kills both.
        clear_bodies();
        head1 = pos(5, 5); len1 = 1; body1[0] = pos(5, 5);
        head2 = pos(7, 5); len2 = 1; body2[0] = pos(7, 5);
        keystroke = 13'b1_0000_0100_1000;
        do_tick();
        check("t3_head1", next_head1, pos(6, 5));
        check("t3_head2", next_head2, pos(6, 5));
        check("t3_dead", {dead1, dead2}, 2'b11);
        do_restart("idle");

        // Randomised rounds in a small arena so hits and food happen.
        for (int r = 0; r < 24; r++) begin
            if (m_dead1 || m_dead2) do_restart("rnd");
            for (int i = 0; i < 16; i++) begin
                body1[i] = ($urandom_range(0, 6) == 0) ? 10'h3FF : rnd_pos();
                body2[i] = ($urandom_range(0, 6) == 0) ? 10'h3FF : rnd_pos();
            end
            head1 = rnd_pos();
            head2 = rnd_pos();
            len1 = IW'($urandom_range(0, 15));
            len2 = IW'($urandom_range(0, 15));
            keystroke = '0;
            keystroke[12] = 1'($urandom_range(0, 3) != 0);
            keystroke[3:0] = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            keystroke[7:4] = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            food1 = ($urandom_range(0, 2) == 0) ? m_move(head1, m_pick(keystroke[3:0], m_dir1)) : rnd_pos();
            food2 = ($urandom_range(0, 2) == 0) ? m_move(head2, m_pick(keystroke[7:4], m_dir2)) : rnd_pos();
            do_tick();
        end

        // Asynchronous reset in the middle of a sequence.
        if (m_dead1 || m_dead2) do_restart("pre_rst");
        clear_bodies();
        keystroke = 13'b1_0000_0000_0000;
        push_aborted();
        wait_busy(1'b1, "rst_seq_start");
        repeat (5) @(negedge clk_raw);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_head1", next_head1, 0);
        check("midrst_steps", {step1, step2, grow1, grow2}, 0);
        @(negedge clk_raw);
        rst_n = 1'b1;
        m_dir1 = 3;
        m_dir2 = 2;
        repeat (3) @(negedge clk_raw);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
